// File: rtl/bomb_pkg.sv
// Shared types and widths for the bomb-game round controller and its helpers.
package bomb_pkg;

  localparam int TIME_W = 8;
  localparam int TRY_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHOW  = 3'd1,
    S_INPUT = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  // Countdown load never drops below one second and never exceeds the display range.
  function automatic logic [TIME_W-1:0] clamp_time(input int t);
    if (t < 1)        return TIME_W'(1);
    else if (t > 255) return TIME_W'(255);
    else              return TIME_W'(t);
  endfunction

endpackage

// File: rtl/bomb_round_ctrl_if.sv
// Board-side and game-block-side signals of the round controller, grouped as one bus.
interface bomb_round_ctrl_if #(
  parameter int LEVELS = 4
);
  import bomb_pkg::*;

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  logic                sw_arm;
  logic                btn_start;
  logic                end_of_show;
  logic                try_valid;
  logic                try_ok;
  logic                face_done;
  logic                rnd_load;
  logic                showing;
  logic                start_input;
  logic                bomb_on;
  logic [TIME_W-1:0]   time_left;
  logic [TRY_W-1:0]    tries_left;
  logic [LVL_W-1:0]    level;
  logic                win;
  logic                fail;
  logic [2:0]          state_o;

  modport master (
    output sw_arm, btn_start, end_of_show, try_valid, try_ok, face_done,
    input  rnd_load, showing, start_input, bomb_on, time_left, tries_left,
           level, win, fail, state_o
  );

  modport slave (
    input  sw_arm, btn_start, end_of_show, try_valid, try_ok, face_done,
    output rnd_load, showing, start_input, bomb_on, time_left, tries_left,
           level, win, fail, state_o
  );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second tick generator: counts 0..CLK_HZ-1 while enabled, pulses tick on the wrap.
module sec_tick_gen #(
  parameter int CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bomb_round_ctrl.sv
// Round sequencer for the bomb game: IDLE -> SHOW -> INPUT -> WIN/LOSE, with its own
// countdown and retry counter. Define BOMB_LEVEL_EN to enable difficulty levels.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   S_IDLE  | waiting for start with arm switch on
//   S_SHOW  | password being displayed, countdown preloaded
//   S_INPUT | user typing, seconds count down, tries counted
//   S_WIN   | correct password, waiting for face animation
//   S_LOSE  | timeout or out of tries, waiting for animation
module bomb_round_ctrl
  import bomb_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int TIME_S     = 20,
  parameter int MAX_TRIES  = 3,
  parameter int LEVELS     = 4,
  parameter int LEVEL_STEP = 4
) (
  input logic              clk,
  input logic              rst_n,
  bomb_round_ctrl_if.slave bus
);

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  state_t             state_q, state_d;
  logic [TIME_W-1:0]  time_q, time_d, load_time;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [LVL_W-1:0]   level_v;
  logic               rnd_q, rnd_d, win_q, win_d, fail_q, fail_d;
  logic               showing_q, input_q, bomb_q;
  logic               in_input, tick;

  assign in_input = (state_q == S_INPUT);

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_input),
    .clr  (!in_input),
    .tick (tick)
  );

`ifdef BOMB_LEVEL_EN
  logic [LVL_W-1:0] level_q, level_d;
  assign level_v = level_q;
`else
  assign level_v = '0;
`endif

  assign load_time = clamp_time(TIME_S - int'(level_v) * LEVEL_STEP);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tries_d = tries_q;
    rnd_d   = 1'b0;
    win_d   = 1'b0;
    fail_d  = 1'b0;
`ifdef BOMB_LEVEL_EN
    level_d = level_q;
`endif
    if (!bus.sw_arm && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tries_d = TRY_W'(MAX_TRIES);
          if (bus.btn_start && bus.sw_arm) begin
            state_d = S_SHOW;
            rnd_d   = 1'b1;
          end
        end
        S_SHOW: begin
          time_d = load_time;
          if (bus.end_of_show) state_d = S_INPUT;
        end
        S_INPUT: begin
          // A correct answer beats the last tick; the last tick beats a wrong answer.
          if (bus.try_valid && bus.try_ok) begin
            state_d = S_WIN;
            win_d   = 1'b1;
          end else if (tick && time_q <= TIME_W'(1)) begin
            time_d  = '0;
            state_d = S_LOSE;
            fail_d  = 1'b1;
`ifdef BOMB_LEVEL_EN
            level_d = '0;
`endif
          end else begin
            if (tick) time_d = time_q - 1'b1;
            if (bus.try_valid) begin
              if (tries_q <= TRY_W'(1)) begin
                tries_d = '0;
                state_d = S_LOSE;
                fail_d  = 1'b1;
`ifdef BOMB_LEVEL_EN
                level_d = '0;
`endif
              end else begin
                tries_d = tries_q - 1'b1;
              end
            end
          end
        end
        S_WIN: begin
          if (bus.face_done) begin
            state_d = S_IDLE;
`ifdef BOMB_LEVEL_EN
            if (level_q != LVL_W'(LEVELS - 1)) level_d = level_q + 1'b1;
`endif
          end
        end
        S_LOSE: begin
          if (bus.face_done) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      time_q    <= TIME_W'(TIME_S);
      tries_q   <= TRY_W'(MAX_TRIES);
      rnd_q     <= 1'b0;
      win_q     <= 1'b0;
      fail_q    <= 1'b0;
      showing_q <= 1'b0;
      input_q   <= 1'b0;
      bomb_q    <= 1'b0;
`ifdef BOMB_LEVEL_EN
      level_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      tries_q   <= tries_d;
      rnd_q     <= rnd_d;
      win_q     <= win_d;
      fail_q    <= fail_d;
      showing_q <= (state_d == S_SHOW);
      input_q   <= (state_d == S_INPUT);
      bomb_q    <= (state_d == S_SHOW) || (state_d == S_INPUT);
`ifdef BOMB_LEVEL_EN
      level_q   <= level_d;
`endif
    end
  end

  assign bus.rnd_load    = rnd_q;
  assign bus.showing     = showing_q;
  assign bus.start_input = input_q;
  assign bus.bomb_on     = bomb_q;
  assign bus.time_left   = time_q;
  assign bus.tries_left  = tries_q;
  assign bus.level       = level_v;
  assign bus.win         = win_q;
  assign bus.fail        = fail_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_bomb_round_ctrl.sv
// Self-checking bench for bomb_round_ctrl: directed scenarios plus random play against
// a round-level model. Level checks are active when BOMB_LEVEL_EN is defined.
module tb_bomb_round_ctrl;

  localparam int CLK_HZ     = 4;
  localparam int TIME_S     = 5;
  localparam int MAX_TRIES  = 3;
  localparam int LEVELS     = 4;
  localparam int LEVEL_STEP = 2;
`ifdef BOMB_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  bomb_round_ctrl_if #(.LEVELS(LEVELS)) bus ();

  bomb_round_ctrl #(
    .CLK_HZ(CLK_HZ), .TIME_S(TIME_S), .MAX_TRIES(MAX_TRIES),
    .LEVELS(LEVELS), .LEVEL_STEP(LEVEL_STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Round-level model: time left is derived from cycles spent in INPUT, tries from
  // the count of wrong answers this round.
  int m_st, m_time, m_tries, m_level, m_load, m_elapsed, m_wrong;
  bit m_rnd, m_win, m_fail;

  function automatic int exp_load(input int lvl);
    int t;
    t = LVL_EN ? TIME_S - lvl * LEVEL_STEP : TIME_S;
    return (t < 1) ? 1 : t;
  endfunction

  task automatic model_reset();
    m_st = 0; m_time = TIME_S; m_tries = MAX_TRIES; m_level = 0;
    m_load = TIME_S; m_elapsed = 0; m_wrong = 0;
    m_rnd = 0; m_win = 0; m_fail = 0;
  endtask

  task automatic model_lose();
    m_st = 4; m_fail = 1;
    if (LVL_EN) m_level = 0;
  endtask

  task automatic model_edge(input bit arm, start, eos, tv, tok, fd);
    int remaining;
    m_rnd = 0; m_win = 0; m_fail = 0;
    if (!arm && m_st != 0) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: begin
          m_wrong = 0; m_tries = MAX_TRIES;
          if (start && arm) begin m_st = 1; m_rnd = 1; end
        end
        1: begin
          m_time = exp_load(m_level);
          if (eos) begin m_st = 2; m_load = m_time; m_elapsed = 0; end
        end
        2: begin
          m_elapsed++;
          remaining = m_load - m_elapsed / CLK_HZ;
          if (tv && tok) begin
            m_st = 3; m_win = 1;
          end else if (remaining <= 0) begin
            m_time = 0;
            model_lose();
          end else begin
            m_time = remaining;
            if (tv) begin
              m_wrong++;
              m_tries = (MAX_TRIES - m_wrong < 0) ? 0 : MAX_TRIES - m_wrong;
              if (m_tries == 0) model_lose();
            end
          end
        end
        3: if (fd) begin
          m_st = 0;
          if (LVL_EN && m_level < LEVELS - 1) m_level++;
        end
        4: if (fd) m_st = 0;
        default: m_st = 0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_edge(bus.sw_arm, bus.btn_start, bus.end_of_show,
                    bus.try_valid, bus.try_ok, bus.face_done);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state_o",     int'(bus.state_o),     m_st);
      chk("time_left",   int'(bus.time_left),   m_time);
      chk("tries_left",  int'(bus.tries_left),  m_tries);
      chk("level",       int'(bus.level),       m_level);
      chk("rnd_load",    int'(bus.rnd_load),    int'(m_rnd));
      chk("win",         int'(bus.win),         int'(m_win));
      chk("fail",        int'(bus.fail),        int'(m_fail));
      chk("showing",     int'(bus.showing),     int'(m_st == 1));
      chk("start_input", int'(bus.start_input), int'(m_st == 2));
      chk("bomb_on",     int'(bus.bomb_on),     int'(m_st == 1 || m_st == 2));
    end
  end

  task automatic drive(input bit arm, start, eos, tv, tok, fd);
    bus.sw_arm = arm; bus.btn_start = start; bus.end_of_show = eos;
    bus.try_valid = tv; bus.try_ok = tok; bus.face_done = fd;
  endtask

  // Apply inputs for one cycle; returns at the next falling edge.
  task automatic step(input bit arm, start, eos, tv, tok, fd);
    drive(arm, start, eos, tv, tok, fd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic enter_input();
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
  endtask

  task automatic lose_by_tries();
    enter_input();
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("reset state", int'(bus.state_o), 0);
    chk("reset time", int'(bus.time_left), 5);
    chk("reset tries", int'(bus.tries_left), 3);
    chk("reset level", int'(bus.level), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Nominal win
    step(1, 1, 0, 0, 0, 0);
    chk("win: rnd_load", int'(bus.rnd_load), 1);
    chk("win: show state", int'(bus.state_o), 1);
    step(1, 0, 1, 0, 0, 0);
    chk("win: input time", int'(bus.time_left), 5);
    idle(9);
    chk("win: time after 9", int'(bus.time_left), 3);
    step(1, 0, 0, 1, 1, 0);
    chk("win: pulse", int'(bus.win), 1);
    chk("win: state", int'(bus.state_o), 3);
    idle(1);
    chk("win: pulse once", int'(bus.win), 0);
    step(1, 0, 0, 0, 0, 1);
    chk("win: back idle", int'(bus.state_o), 0);

    // Timeout
    enter_input();
    idle(19);
    chk("timeout: time before", int'(bus.time_left), 1);
    idle(1);
    chk("timeout: time", int'(bus.time_left), 0);
    chk("timeout: state", int'(bus.state_o), 4);
    chk("timeout: fail", int'(bus.fail), 1);
    idle(4);
    chk("timeout: holds", int'(bus.state_o), 4);
    chk("timeout: fail once", int'(bus.fail), 0);
    step(1, 0, 0, 0, 0, 1);

    // Retries
    enter_input();
    step(1, 0, 0, 1, 0, 0);
    chk("retry: tries 2", int'(bus.tries_left), 2);
    step(1, 0, 0, 1, 0, 0);
    chk("retry: tries 1", int'(bus.tries_left), 1);
    step(1, 0, 0, 1, 0, 0);
    chk("retry: tries 0", int'(bus.tries_left), 0);
    chk("retry: fail", int'(bus.fail), 1);
    chk("retry: state", int'(bus.state_o), 4);
    step(1, 0, 0, 0, 0, 1);

    // Correct try on the final tick
    enter_input();
    idle(19);
    step(1, 0, 0, 1, 1, 0);
    chk("simul: state", int'(bus.state_o), 3);
    chk("simul: win", int'(bus.win), 1);
    chk("simul: no fail", int'(bus.fail), 0);
    chk("simul: time frozen", int'(bus.time_left), 1);
    step(1, 0, 0, 0, 0, 1);

    // Abort during INPUT
    enter_input();
    idle(3);
    step(0, 0, 0, 0, 0, 0);
    chk("abort: state", int'(bus.state_o), 0);
    chk("abort: no fail", int'(bus.fail), 0);
    chk("abort: no win", int'(bus.win), 0);
    step(0, 1, 0, 0, 0, 0);
    chk("abort: start disarmed", int'(bus.state_o), 0);

    // Reset while showing
    step(1, 1, 0, 0, 0, 0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid: state", int'(bus.state_o), 0);
    chk("rst mid: showing", int'(bus.showing), 0);
    chk("rst mid: bomb_on", int'(bus.bomb_on), 0);
    chk("rst mid: time", int'(bus.time_left), 5);
    chk("rst mid: tries", int'(bus.tries_left), 3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

`ifdef BOMB_LEVEL_EN
    begin
      int loads[4] = '{5, 3, 1, 1};
      for (int r = 0; r < 4; r++) begin
        enter_input();
        chk("level: load", int'(bus.time_left), loads[r]);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 1);
      end
      chk("level: saturated", int'(bus.level), 3);
      lose_by_tries();
      chk("level: after loss", int'(bus.level), 0);
      enter_input();
      chk("level: load after loss", int'(bus.time_left), 5);
      step(0, 0, 0, 0, 0, 0);
    end
`else
    lose_by_tries();
    enter_input();
    chk("level off: load", int'(bus.time_left), 5);
    chk("level off: level", int'(bus.level), 0);
    step(0, 0, 0, 0, 0, 0);
`endif

    // Random play
    for (int i = 0; i < 3000; i++) begin
      bit arm, start, eos, tv, tok, fd;
      arm   = ($urandom_range(99) < 97);
      start = ($urandom_range(99) < 25);
      eos   = ($urandom_range(99) < 30);
      tv    = ($urandom_range(99) < 6);
      tok   = ($urandom_range(99) < 40);
      fd    = ($urandom_range(99) < 15);
      step(arm, start, eos, tv, tok, fd);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bomb_round_ctrl.md
Name: bomb_round_ctrl

Overview:
- Parametrised game controller for the bomb-dismantlement game. It sequences IDLE, password show, timed input, then WIN or LOSE.
- Owns its own seconds countdown and retry counter, so separate countdown and fail sources are not needed.
- Sits between the board switches/buttons and the password, display, matrix and face/beeper blocks.

Parameters:
- CLK_HZ, 1000: clk cycles per one-second tick.
- TIME_S, 20: countdown seconds loaded on entering INPUT (1..255).
- MAX_TRIES, 3: wrong submissions allowed before LOSE (1..15).
- LEVELS, 4: number of difficulty levels (used only with the optional feature).
- LEVEL_STEP, 4: seconds removed from TIME_S per level.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw_arm  in  1  arm switch; low forces abort to IDLE
- btn_start  in  1  single-cycle start pulse (already debounced)
- end_of_show  in  1  pulse from the password display when the show finishes
- try_valid  in  1  pulse: user submitted a password
- try_ok  in  1  submission matched; sampled only with try_valid
- face_done  in  1  pulse: win/lose animation finished
- rnd_load  out  1  one-cycle pulse latching a new random password
- showing  out  1  high in SHOW
- start_input  out  1  high in INPUT
- bomb_on  out  1  high in SHOW and INPUT
- time_left  out  8  seconds remaining
- tries_left  out  4  remaining wrong submissions
- level  out  $clog2(LEVELS)  current level (0 when feature off)
- win  out  1  one-cycle pulse on entering WIN
- fail  out  1  one-cycle pulse on entering LOSE
- state_o  out  3  encoded state: IDLE=0, SHOW=1, INPUT=2, WIN=3, LOSE=4

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all pulses 0; showing/start_input/bomb_on 0.
  - time_left=TIME_S; tries_left=MAX_TRIES; level=0; tick counter 0.
- Tick generator:
  - Counter runs 0..CLK_HZ-1 only in INPUT; tick pulses when it wraps.
  - Counter clears on every INPUT entry, so the first tick comes exactly CLK_HZ cycles after entry.
- IDLE:
  - btn_start and sw_arm: go to SHOW; rnd_load=1 in that same cycle.
  - Load tries_left=MAX_TRIES.
- SHOW:
  - end_of_show: go to INPUT.
  - Load time_left with the level-adjusted time (see Optional Feature).
- INPUT:
  - tick: time_left decrements; the decrement that would reach 0 goes to LOSE with time_left=0.
  - try_valid with try_ok=1: go to WIN.
  - try_valid with try_ok=0: tries_left decrements; if it was 1, go to LOSE.
  - Priority within one cycle: correct try > timeout > wrong try.
  - try_valid outside INPUT is ignored.
- WIN/LOSE:
  - win or fail pulses for exactly one cycle on entry.
  - Stay until face_done, then go to IDLE.
  - time_left and tries_left are frozen for display.
- Abort: sw_arm=0 in any state except IDLE goes to IDLE on the next edge. No win/fail pulse; level is kept.
- Mid-operation reset: immediate return to reset values, regardless of state.
- btn_start outside IDLE is ignored.
- Counters never underflow; tries_left and time_left saturate at 0.

Optional Feature:
- Macro: BOMB_LEVEL_EN.
- Defined:
  - On a WIN→IDLE exit, level increments, saturating at LEVELS-1. LOSE resets level to 0.
  - INPUT load value = max(1, TIME_S - level*LEVEL_STEP), computed at 9 bits before clamping.
- Undefined:
  - level is tied to 0.
  - time_left load is always TIME_S.
  - No level register is synthesised.

Decomposition:
- Shared package bomb_pkg: state encoding enum (IDLE/SHOW/INPUT/WIN/LOSE), TIME_W=8, TRY_W=4.
- One natural sub-module, sec_tick_gen:
  - Parameter CLK_HZ; inputs clk, rst_n, en, clr; output tick.
  - Reusable by the display blocks.
- FSM and counters stay in bomb_round_ctrl.

Test Plan (CLK_HZ=4, TIME_S=5, MAX_TRIES=3, LEVELS=4, LEVEL_STEP=2):
- Nominal win: reset, sw_arm=1, btn_start → SHOW with rnd_load pulse. end_of_show → INPUT, time_left=5. After 9 cycles time_left=3. try_valid, try_ok=1 → win pulse, state 3. face_done → IDLE.
- Timeout: enter INPUT, no tries → after 20 cycles time_left=0, state 4, fail pulses once. Stays in LOSE without face_done.
- Retries: three wrong try_valid pulses → tries_left 2, 1, then LOSE with fail=1 and tries_left=0.
- Simultaneous: correct try in the same cycle as the final tick → WIN, no fail pulse.
- Abort and reset:
  - sw_arm=0 during INPUT → IDLE next edge, no pulses.
  - rst_n low mid-SHOW → IDLE asynchronously with all reset values.
- BOMB_LEVEL_EN:
  - Three consecutive wins → INPUT loads 5, 3, 1.
  - Fourth win: level saturates at 3, load stays 1.
  - A loss → level 0, load 5.
